gyro_pat_chk: RTL and testbench

Parametrised receive-pattern checker for the gyro tester loopback paths (LOOP1/2/3, RX-bypass, SR-RX pattern tests). It sits after the deserialiser on the DRX path. It locks onto a known transmit pattern: incrementing counter, walking one, LFSR, or a constant. It then counts mismatching words in hardware, replacing post-simulation file comparison and enabling on-board BER checks through the register map.

---
 rtl/gyro_pat_chk_if.sv | 29 ++
 rtl/gyro_pat_chk.sv | 179 +++++++++++++++++
 tb/tb_gyro_pat_chk.sv | 354 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/gyro_pat_chk_if.sv
// Signal bundle between the DRX deserialiser side and the gyro pattern checker.
// The master drives the word stream and controls; the slave reports lock and error status.
interface gyro_pat_chk_if #(
    parameter int DATA_W = 32,
    parameter int ERR_W  = 16,
    parameter int WCNT_W = 32
);
    logic              en;
    logic [1:0]        mode;
    logic [DATA_W-1:0] cfg_seed;
    logic              clr_cnt;
    logic              din_valid;
    logic [DATA_W-1:0] din;
    logic              locked;
    logic              err_pulse;
    logic [ERR_W-1:0]  err_cnt;
    logic [WCNT_W-1:0] word_cnt;
    logic [1:0]        state;

    modport master (
        output en, mode, cfg_seed, clr_cnt, din_valid, din,
        input  locked, err_pulse, err_cnt, word_cnt, state
    );

    modport slave (
        input  en, mode, cfg_seed, clr_cnt, din_valid, din,
        output locked, err_pulse, err_cnt, word_cnt, state
    );
endinterface

// File: rtl/gyro_pat_chk.sv
// Receive-pattern checker: locks onto a counter / walking-one / LFSR / constant stream
// and counts mismatching words once locked, with a flywheel predictor.
//
// state     | meaning
// ----------+----------------------------------------------------------
// ST_IDLE   | checker disabled; counters hold, prediction history dropped
// ST_HUNT   | looking for LOCK_CNT consecutive predicted words
// ST_LOCKED | comparing every valid word against the flywheel prediction
module gyro_pat_chk #(
    parameter int                DATA_W     = 32,
    parameter int                LOCK_CNT   = 4,
    parameter int                UNLOCK_CNT = 8,
    parameter int                ERR_W      = 16,
    parameter int                WCNT_W     = 32,
    parameter logic [DATA_W-1:0] LFSR_TAPS  = DATA_W'(32'h8020_0003)
) (
    input  logic           ACLK,
    input  logic           ARESET,
    gyro_pat_chk_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_HUNT   = 2'd1,
        ST_LOCKED = 2'd2
    } st_t;

    localparam logic [7:0] LOCK_RUN   = 8'(LOCK_CNT);
    localparam logic [7:0] UNLOCK_RUN = 8'(UNLOCK_CNT);

    st_t               st_q, st_d;
    logic [DATA_W-1:0] exp_q, exp_d;
    logic              has_prev_q, has_prev_d;
    logic [7:0]        match_run_q, match_run_d;
    logic [7:0]        miss_run_q, miss_run_d;
    logic              err_pulse_q, err_pulse_d;
    logic [ERR_W-1:0]  err_cnt_q, err_cnt_d;
    logic [WCNT_W-1:0] word_cnt_q, word_cnt_d;
    logic              locked_q, locked_d;
    logic [1:0]        mode_q;

    logic              hunt_hit;
    logic [7:0]        match_inc;
    logic [7:0]        miss_inc;

    function automatic logic [DATA_W-1:0] nxt(
        input logic [1:0]        m,
        input logic [DATA_W-1:0] x,
        input logic [DATA_W-1:0] seed
    );
        logic [DATA_W-1:0] r;
        case (m)
            2'd0:    r = x + DATA_W'(1);
            2'd1:    r = {x[DATA_W-2:0], x[DATA_W-1]};
            2'd2:    r = {x[DATA_W-2:0], ^(x & LFSR_TAPS)};
            default: r = seed;
        endcase
        return r;
    endfunction

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            st_q        <= ST_IDLE;
            exp_q       <= '0;
            has_prev_q  <= 1'b0;
            match_run_q <= '0;
            miss_run_q  <= '0;
            err_pulse_q <= 1'b0;
            err_cnt_q   <= '0;
            word_cnt_q  <= '0;
            locked_q    <= 1'b0;
            mode_q      <= 2'd0;
        end else begin
            st_q        <= st_d;
            exp_q       <= exp_d;
            has_prev_q  <= has_prev_d;
            match_run_q <= match_run_d;
            miss_run_q  <= miss_run_d;
            err_pulse_q <= err_pulse_d;
            err_cnt_q   <= err_cnt_d;
            word_cnt_q  <= word_cnt_d;
            locked_q    <= locked_d;
            mode_q      <= bus.mode;
        end
    end

    // Constant mode needs no history; the other modes predict from the previous word.
    assign hunt_hit  = (bus.mode == 2'd3) ? (bus.din == bus.cfg_seed)
                                          : (has_prev_q && (bus.din == exp_q));
    assign match_inc = match_run_q + 8'd1;
    assign miss_inc  = miss_run_q + 8'd1;

    always_comb begin
        st_d        = st_q;
        exp_d       = exp_q;
        has_prev_d  = has_prev_q;
        match_run_d = match_run_q;
        miss_run_d  = miss_run_q;
        err_pulse_d = 1'b0;
        err_cnt_d   = err_cnt_q;
        word_cnt_d  = word_cnt_q;

        if (!bus.en) begin
            st_d        = ST_IDLE;
            has_prev_d  = 1'b0;
            match_run_d = '0;
            miss_run_d  = '0;
        end else if (bus.mode != mode_q) begin
            // The word seen during a mode switch belongs to neither pattern.
            st_d        = ST_HUNT;
            has_prev_d  = 1'b0;
            match_run_d = '0;
            miss_run_d  = '0;
        end else begin
            case (st_q)
                ST_IDLE: begin
                    st_d = ST_HUNT;
                end
                ST_HUNT: begin
                    if (bus.din_valid) begin
                        exp_d      = nxt(bus.mode, bus.din, bus.cfg_seed);
                        has_prev_d = 1'b1;
                        if (hunt_hit) begin
                            match_run_d = match_inc;
                            if (match_inc >= LOCK_RUN) begin
                                st_d        = ST_LOCKED;
                                match_run_d = '0;
                                miss_run_d  = '0;
                            end
                        end else begin
                            match_run_d = '0;
                        end
                    end
                end
                ST_LOCKED: begin
                    if (bus.din_valid) begin
                        // Flywheel: advance from the prediction, not the received word.
                        exp_d = nxt(bus.mode, exp_q, bus.cfg_seed);
                        if (!(&word_cnt_q)) begin
                            word_cnt_d = word_cnt_q + WCNT_W'(1);
                        end
                        if (bus.din != exp_q) begin
                            err_pulse_d = 1'b1;
                            if (!(&err_cnt_q)) begin
                                err_cnt_d = err_cnt_q + ERR_W'(1);
                            end
                            miss_run_d = miss_inc;
                            if (miss_inc >= UNLOCK_RUN) begin
                                st_d        = ST_HUNT;
                                has_prev_d  = 1'b0;
                                match_run_d = '0;
                                miss_run_d  = '0;
                            end
                        end else begin
                            miss_run_d = '0;
                        end
                    end
                end
                default: begin
                    st_d = ST_IDLE;
                end
            endcase
        end

        if (bus.clr_cnt) begin
            err_cnt_d  = '0;
            word_cnt_d = '0;
        end
    end

    assign locked_d = (st_d == ST_LOCKED);

    assign bus.locked    = locked_q;
    assign bus.err_pulse = err_pulse_q;
    assign bus.err_cnt   = err_cnt_q;
    assign bus.word_cnt  = word_cnt_q;
    assign bus.state     = st_q;

endmodule

// File: tb/tb_gyro_pat_chk.sv
// Bench for gyro_pat_chk: directed vector table, hand-written corner sequences and
// randomized streams checked against a word-level reference model.
module tb_gyro_pat_chk;

    localparam int          LOCK_N = 4;
    localparam bit [31:0]   TAPS   = 32'h8020_0003;
    localparam longint      TWO32  = 64'sh1_0000_0000;
    localparam longint      WMAX   = TWO32 - 1;

    logic tb_ACLK = 1'b0;
    logic tb_ARESET;
    always #5 tb_ACLK = ~tb_ACLK;

    gyro_pat_chk_if #(.DATA_W(32), .ERR_W(16), .WCNT_W(32)) ifa ();
    gyro_pat_chk_if #(.DATA_W(32), .ERR_W(4),  .WCNT_W(32)) ifb ();

    gyro_pat_chk #(.DATA_W(32), .LOCK_CNT(4), .UNLOCK_CNT(8), .ERR_W(16), .WCNT_W(32))
        dut_a (.ACLK(tb_ACLK), .ARESET(tb_ARESET), .bus(ifa));
    gyro_pat_chk #(.DATA_W(32), .LOCK_CNT(4), .UNLOCK_CNT(255), .ERR_W(4), .WCNT_W(32))
        dut_b (.ACLK(tb_ACLK), .ARESET(tb_ARESET), .bus(ifb));

    typedef struct {
        bit        en;
        bit [1:0]  mode;
        bit [31:0] seed;
        bit        clr;
        bit        valid;
        bit [31:0] din;
    } in_t;

    typedef struct {
        int        st;
        bit [31:0] expw;
        bit        prev;
        int        mrun;
        int        xrun;
        longint    err;
        longint    wcnt;
        bit        pulse;
        bit [1:0]  last_mode;
    } mdl_t;

    typedef struct {
        bit        en;
        bit [1:0]  mode;
        bit        valid;
        bit        clr;
        bit [31:0] din;
        bit        lk;
        bit        pl;
        int        err;
        longint    wc;
        int        st;
    } vec_t;

    int        n_cmp = 0;
    int        n_bad = 0;
    mdl_t      ma, mb;
    vec_t      vec [$];
    bit [31:0] wl [5];
    bit [31:0] x, tx, seed;
    bit [1:0]  rm;
    int        burst;

    function automatic bit [31:0] ref_nxt(input bit [1:0] m, input bit [31:0] w, input bit [31:0] s);
        longint v = longint'(w);
        case (m)
            2'd0:    v = (v + 1) % TWO32;
            2'd1:    v = (v * 2) % TWO32 + v / (TWO32 / 2);
            2'd2:    v = (v * 2) % TWO32 + ($countones(w & TAPS) % 2);
            default: v = longint'(s);
        endcase
        return 32'(v);
    endfunction

    function automatic mdl_t mdl_reset();
        mdl_t z;
        z.st = 0; z.expw = 0; z.prev = 0; z.mrun = 0; z.xrun = 0;
        z.err = 0; z.wcnt = 0; z.pulse = 0; z.last_mode = 0;
        return z;
    endfunction

    // One clock of the checker described as word-level rules.
    function automatic mdl_t model_step(input mdl_t m, input in_t i, input int unlock, input int err_bits);
        mdl_t   r = m;
        longint emax = (longint'(1) << err_bits) - 1;
        bit     hit;
        r.pulse = 0;
        if (!i.en) begin
            r.st = 0; r.prev = 0; r.mrun = 0; r.xrun = 0;
        end else if (i.mode != m.last_mode) begin
            r.st = 1; r.prev = 0; r.mrun = 0; r.xrun = 0;
        end else if (m.st == 0) begin
            r.st = 1;
        end else if (i.valid && m.st == 1) begin
            hit = (i.mode == 2'd3) ? (i.din == i.seed) : (m.prev && i.din == m.expw);
            r.mrun = hit ? m.mrun + 1 : 0;
            r.prev = 1;
            r.expw = ref_nxt(i.mode, i.din, i.seed);
            if (r.mrun >= LOCK_N) begin
                r.st = 2; r.xrun = 0;
            end
        end else if (i.valid && m.st == 2) begin
            r.wcnt = (m.wcnt < WMAX) ? m.wcnt + 1 : m.wcnt;
            if (i.din != m.expw) begin
                r.pulse = 1;
                r.err   = (m.err < emax) ? m.err + 1 : m.err;
                r.xrun  = m.xrun + 1;
                if (r.xrun >= unlock) begin
                    r.st = 1; r.prev = 0; r.mrun = 0; r.xrun = 0;
                end
            end else begin
                r.xrun = 0;
            end
            r.expw = ref_nxt(i.mode, m.expw, i.seed);
        end
        if (i.clr) begin
            r.err = 0; r.wcnt = 0;
        end
        r.last_mode = i.mode;
        return r;
    endfunction

    function automatic vec_t mkv(input bit e, input bit [1:0] md, input bit v, input bit c,
                                 input bit [31:0] d, input bit lk, input bit pl,
                                 input int err, input longint wc, input int st);
        vec_t t;
        t.en = e; t.mode = md; t.valid = v; t.clr = c; t.din = d;
        t.lk = lk; t.pl = pl; t.err = err; t.wc = wc; t.st = st;
        return t;
    endfunction

    function automatic bit [31:0] start_word(input bit [1:0] m, input bit [31:0] s);
        case (m)
            2'd0:    return 32'hFFFF_FFF8;
            2'd1:    return 32'h0000_0001;
            2'd2:    return s | 32'h1;
            default: return s;
        endcase
    endfunction

    task automatic cmp(input string name, input longint act, input longint req);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic set_a(input bit e, input bit [1:0] md, input bit v, input bit c, input bit [31:0] d);
        ifa.en = e; ifa.mode = md; ifa.din_valid = v; ifa.clr_cnt = c; ifa.din = d;
    endtask

    task automatic set_b(input bit e, input bit [1:0] md, input bit v, input bit c, input bit [31:0] d);
        ifb.en = e; ifb.mode = md; ifb.din_valid = v; ifb.clr_cnt = c; ifb.din = d;
    endtask

    task automatic check_zero(input string tag);
        cmp({tag, ".a.locked"},    ifa.locked,    0);
        cmp({tag, ".a.err_pulse"}, ifa.err_pulse, 0);
        cmp({tag, ".a.err_cnt"},   ifa.err_cnt,   0);
        cmp({tag, ".a.word_cnt"},  ifa.word_cnt,  0);
        cmp({tag, ".a.state"},     ifa.state,     0);
        cmp({tag, ".b.locked"},    ifb.locked,    0);
        cmp({tag, ".b.err_cnt"},   ifb.err_cnt,   0);
        cmp({tag, ".b.state"},     ifb.state,     0);
    endtask

    // Apply the current inputs for one clock, then compare both DUTs with the model.
    task automatic tick();
        in_t ia, ib;
        ia = '{ifa.en, ifa.mode, ifa.cfg_seed, ifa.clr_cnt, ifa.din_valid, ifa.din};
        ib = '{ifb.en, ifb.mode, ifb.cfg_seed, ifb.clr_cnt, ifb.din_valid, ifb.din};
        @(posedge tb_ACLK);
        #1;
        ma = model_step(ma, ia, 8, 16);
        mb = model_step(mb, ib, 255, 4);
        cmp("mdl.a.locked",    ifa.locked,    (ma.st == 2) ? 1 : 0);
        cmp("mdl.a.err_pulse", ifa.err_pulse, ma.pulse);
        cmp("mdl.a.err_cnt",   ifa.err_cnt,   ma.err);
        cmp("mdl.a.word_cnt",  ifa.word_cnt,  ma.wcnt);
        cmp("mdl.a.state",     ifa.state,     ma.st);
        cmp("mdl.b.locked",    ifb.locked,    (mb.st == 2) ? 1 : 0);
        cmp("mdl.b.err_pulse", ifb.err_pulse, mb.pulse);
        cmp("mdl.b.err_cnt",   ifb.err_cnt,   mb.err);
        cmp("mdl.b.word_cnt",  ifb.word_cnt,  mb.wcnt);
        cmp("mdl.b.state",     ifb.state,     mb.st);
    endtask

    initial begin
        // Counter lock, flywheel single error, loss of lock, relock, hold and clear.
        vec.push_back(mkv(1'b1, 2'd0, 1'b0, 1'b0, 32'h0,  1'b0, 1'b0, 0, 0, 1));
        vec.push_back(mkv(1'b1, 2'd0, 1'b1, 1'b0, 32'h10, 1'b0, 1'b0, 0, 0, 1));
        vec.push_back(mkv(1'b1, 2'd0, 1'b1, 1'b0, 32'h11, 1'b0, 1'b0, 0, 0, 1));
        vec.push_back(mkv(1'b1, 2'd0, 1'b1, 1'b0, 32'h12, 1'b0, 1'b0, 0, 0, 1));
        vec.push_back(mkv(1'b1, 2'd0, 1'b1, 1'b0, 32'h13, 1'b0, 1'b0, 0, 0, 1));
        vec.push_back(mkv(1'b1, 2'd0, 1'b1, 1'b0, 32'h14, 1'b1, 1'b0, 0, 0, 2));
        vec.push_back(mkv(1'b1, 2'd0, 1'b1, 1'b0, 32'h15, 1'b1, 1'b0, 0, 1, 2));
        vec.push_back(mkv(1'b1, 2'd0, 1'b1, 1'b0, 32'h16, 1'b1, 1'b0, 0, 2, 2));
        vec.push_back(mkv(1'b1, 2'd0, 1'b1, 1'b0, 32'h99, 1'b1, 1'b1, 1, 3, 2));
        vec.push_back(mkv(1'b1, 2'd0, 1'b1, 1'b0, 32'h18, 1'b1, 1'b0, 1, 4, 2));
        for (int k = 0; k < 8; k++)
            vec.push_back(mkv(1'b1, 2'd0, 1'b1, 1'b0, 32'hDEAD_BEEF, (k != 7), 1'b1,
                              2 + k, 5 + k, (k == 7) ? 1 : 2));
        for (int k = 0; k < 5; k++)
            vec.push_back(mkv(1'b1, 2'd0, 1'b1, 1'b0, 32'h100 + 32'(k), (k == 4), 1'b0,
                              9, 12, (k == 4) ? 2 : 1));
        vec.push_back(mkv(1'b1, 2'd0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 9, 12, 2));
        vec.push_back(mkv(1'b0, 2'd0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 9, 12, 0));
        vec.push_back(mkv(1'b0, 2'd0, 1'b0, 1'b1, 32'h0, 1'b0, 1'b0, 0, 0, 0));

        ifa.cfg_seed = 32'h0;
        ifb.cfg_seed = 32'h0;
        tb_ARESET = 1'b1;
        set_a(1'b1, 2'd0, 1'b1, 1'b0, 32'h0);
        set_b(1'b1, 2'd0, 1'b1, 1'b0, 32'h0);
        #2;
        for (int k = 0; k < 6; k++) begin
            ifa.din = k[0] ? 32'h5555_5555 : 32'hAAAA_AAAA;
            ifb.din = ifa.din;
            @(posedge tb_ACLK);
            #1;
            check_zero("reset");
        end
        set_a(1'b0, 2'd0, 1'b0, 1'b0, 32'h0);
        set_b(1'b0, 2'd0, 1'b0, 1'b0, 32'h0);
        tb_ARESET = 1'b0;
        ma = mdl_reset();
        mb = mdl_reset();
        tick();

        foreach (vec[k]) begin
            set_a(vec[k].en, vec[k].mode, vec[k].valid, vec[k].clr, vec[k].din);
            tick();
            cmp($sformatf("vec%0d.locked", k),    ifa.locked,    vec[k].lk);
            cmp($sformatf("vec%0d.err_pulse", k), ifa.err_pulse, vec[k].pl);
            cmp($sformatf("vec%0d.err_cnt", k),   ifa.err_cnt,   vec[k].err);
            cmp($sformatf("vec%0d.word_cnt", k),  ifa.word_cnt,  vec[k].wc);
            cmp($sformatf("vec%0d.state", k),     ifa.state,     vec[k].st);
        end

        // Walking one across the MSB wrap.
        set_a(1'b1, 2'd1, 1'b0, 1'b0, 32'h0);
        tick();
        cmp("walk.hunt_after_mode", ifa.state, 1);
        wl = '{32'h4000_0000, 32'h8000_0000, 32'h1, 32'h2, 32'h4};
        foreach (wl[k]) begin
            set_a(1'b1, 2'd1, 1'b1, 1'b0, wl[k]);
            tick();
        end
        cmp("walk.locked", ifa.locked, 1);
        set_a(1'b1, 2'd1, 1'b1, 1'b0, 32'h8);
        tick();
        cmp("walk.err_cnt", ifa.err_cnt, 0);
        cmp("walk.word_cnt", ifa.word_cnt, 1);

        // LFSR stream of 1000 words; the first LOCK_CNT+1 are spent acquiring lock.
        set_a(1'b1, 2'd2, 1'b0, 1'b1, 32'h0);
        tick();
        x = 32'h1;
        for (int k = 0; k < 1000; k++) begin
            set_a(1'b1, 2'd2, 1'b1, 1'b0, x);
            tick();
            x = ref_nxt(2'd2, x, 32'h0);
        end
        cmp("lfsr.err_cnt", ifa.err_cnt, 0);
        cmp("lfsr.word_cnt", ifa.word_cnt, 1000 - (LOCK_N + 1));
        cmp("lfsr.locked", ifa.locked, 1);
        set_a(1'b0, 2'd2, 1'b0, 1'b0, 32'h0);

        // Saturation on the 4-bit error counter, clear against a miss, mode change.
        set_b(1'b1, 2'd0, 1'b0, 1'b0, 32'h0);
        tick();
        for (int k = 0; k < 5; k++) begin
            set_b(1'b1, 2'd0, 1'b1, 1'b0, 32'(k));
            tick();
        end
        cmp("sat.locked", ifb.locked, 1);
        for (int k = 0; k < 20; k++) begin
            set_b(1'b1, 2'd0, 1'b1, 1'b0, 32'hA000_0000 + 32'(k));
            tick();
        end
        cmp("sat.err_cnt", ifb.err_cnt, 15);
        cmp("sat.locked_hold", ifb.locked, 1);
        cmp("sat.word_cnt", ifb.word_cnt, 20);
        set_b(1'b1, 2'd0, 1'b1, 1'b1, 32'hA000_0100);
        tick();
        cmp("clr.err_cnt", ifb.err_cnt, 0);
        cmp("clr.word_cnt", ifb.word_cnt, 0);
        cmp("clr.err_pulse", ifb.err_pulse, 1);
        set_b(1'b1, 2'd1, 1'b1, 1'b0, 32'h5);
        tick();
        cmp("modechg.state", ifb.state, 1);
        cmp("modechg.err_pulse", ifb.err_pulse, 0);

        // Randomized streams with sporadic errors, bursts, mode switches and disables.
        seed = $urandom;
        ifa.cfg_seed = seed;
        ifb.cfg_seed = seed;
        rm = 2'd0;
        tx = start_word(rm, seed);
        burst = 0;
        for (int c = 0; c < 4000; c++) begin
            bit        r_en, r_v, r_clr;
            bit [31:0] w;
            if ($urandom_range(0, 299) == 0) begin
                rm = 2'($urandom_range(0, 3));
                tx = start_word(rm, seed);
            end
            r_en  = ($urandom_range(0, 199) != 0);
            r_v   = ($urandom_range(0, 3) != 0);
            r_clr = ($urandom_range(0, 499) == 0);
            if (burst == 0 && $urandom_range(0, 399) == 0) burst = 10;
            w = tx;
            if (r_v) begin
                if (burst > 0) begin
                    w = ~tx;
                    burst--;
                end else if ($urandom_range(0, 24) == 0) begin
                    w = tx ^ (32'h1 << $urandom_range(0, 31));
                end
                tx = ref_nxt(rm, tx, seed);
            end
            set_a(r_en, rm, r_v, r_clr, w);
            set_b(r_en, rm, r_v, r_clr, w);
            tick();
        end

        // Asynchronous reset in the middle of a clock period.
        @(posedge tb_ACLK);
        #3;
        tb_ARESET = 1'b1;
        #1;
        check_zero("areset");
        @(posedge tb_ACLK);
        #1;
        tb_ARESET = 1'b0;
        ma = mdl_reset();
        mb = mdl_reset();
        set_a(1'b1, 2'd0, 1'b0, 1'b0, 32'h0);
        set_b(1'b1, 2'd0, 1'b0, 1'b0, 32'h0);
        tick();
        cmp("post_reset.state", ifa.state, 1);
        for (int k = 0; k < 6; k++) begin
            set_a(1'b1, 2'd0, 1'b1, 1'b0, 32'h7000 + 32'(k));
            tick();
        end
        cmp("post_reset.locked", ifa.locked, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
